// File: rtl/rtc_reset_seq_if.sv
// Handshake/status bundle between rtc_reset_seq and its consumers.
// wdog_kick exists only when RTC_RESET_WDOG_EN is defined.
interface rtc_reset_seq_if #(
  parameter int NUM_CH = 4
) ();
  logic              sw_reset_req;
`ifdef RTC_RESET_WDOG_EN
  logic              wdog_kick;
`endif
  logic [NUM_CH-1:0] reset;
  logic [NUM_CH-1:0] reset_n;
  logic              busy;
  logic              done;
  logic              wdog_flag;

  modport master (
    output sw_reset_req,
`ifdef RTC_RESET_WDOG_EN
    output wdog_kick,
`endif
    input  reset, reset_n, busy, done, wdog_flag
  );

  modport slave (
    input  sw_reset_req,
`ifdef RTC_RESET_WDOG_EN
    input  wdog_kick,
`endif
    output reset, reset_n, busy, done, wdog_flag
  );
endinterface

// File: rtl/rtc_reset_seq.sv
// rtc_reset_seq: staggered per-channel reset release; optional watchdog via RTC_RESET_WDOG_EN.
// Latency: ch0 free SYNC_STAGES+HOLD_CYCLES edges after resetn; no backpressure, outputs registered.
module rtc_reset_seq #(
  parameter int NUM_CH         = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 8,
  parameter int CNT_W          = 8,
  parameter int WDOG_CYCLES    = 200
) (
  input  logic           clk_peripheral,
  input  logic           resetn,
  rtc_reset_seq_if.slave bus
);

  typedef enum logic [1:0] {S_SYNC, S_HOLD, S_RELEASE, S_RUN} state_t;

  localparam logic [NUM_CH-1:0] ALL_ON    = '1;
  localparam logic [NUM_CH-1:0] LAST_CH   = ALL_ON ^ (ALL_ON >> 1);
  localparam bit                DIRECT    = (NUM_CH == 1) || (STAGGER_CYCLES == 0);
  localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);

  if ((HOLD_CYCLES > 2**CNT_W) || (STAGGER_CYCLES > 2**CNT_W) || (WDOG_CYCLES > 2**CNT_W))
  begin : g_cnt_w_chk
    $error("rtc_reset_seq: CNT_W too narrow for configured cycle counts");
  end

  state_t            r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [NUM_CH-1:0] r_reset, w_reset_nxt;
  logic              w_wdog_to;
  logic              w_restart;

  assign w_restart = bus.sw_reset_req | w_wdog_to;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_reset_nxt = r_reset;
    // Any restart outside SYNC re-enters HOLD with every channel asserted.
    if (r_state != S_SYNC && w_restart) begin
      w_state_nxt = S_HOLD;
      w_cnt_nxt   = '0;
      w_reset_nxt = ALL_ON;
    end else begin
      case (r_state)
        S_SYNC: begin
          if (r_sync[SYNC_STAGES-2]) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = '0;
          end
        end
        S_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_cnt_nxt = '0;
            if (DIRECT) begin
              w_reset_nxt = '0;
              w_state_nxt = S_RUN;
            end else begin
              w_reset_nxt = r_reset << 1;
              w_state_nxt = S_RELEASE;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          if (r_cnt == STAG_LAST) begin
            w_cnt_nxt   = '0;
            w_reset_nxt = r_reset << 1;
            if (r_reset == LAST_CH) w_state_nxt = S_RUN;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_peripheral or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_SYNC;
      r_cnt   <= '0;
      r_reset <= ALL_ON;
      r_sync  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_reset <= w_reset_nxt;
      r_sync  <= {r_sync[SYNC_STAGES-2:0], 1'b1};
    end
  end

`ifdef RTC_RESET_WDOG_EN
  logic [CNT_W-1:0] r_wdog_cnt;
  logic             r_wdog_flag;

  // A kick on the timeout edge suppresses the timeout.
  assign w_wdog_to = (r_state == S_RUN) && !bus.wdog_kick &&
                     (r_wdog_cnt == CNT_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk_peripheral or negedge resetn) begin
    if (!resetn)                                            r_wdog_cnt <= '0;
    else if (r_state != S_RUN || bus.wdog_kick || w_restart) r_wdog_cnt <= '0;
    else                                                    r_wdog_cnt <= r_wdog_cnt + 1'b1;
  end

  // Sticky across resetn so software can read the cause after the sequence completes.
  always_ff @(posedge clk_peripheral) begin
    if (r_state == S_SYNC && bus.sw_reset_req) r_wdog_flag <= 1'b0;
    else if (w_wdog_to)                        r_wdog_flag <= 1'b1;
  end

  assign bus.wdog_flag = r_wdog_flag;
`else
  assign w_wdog_to     = 1'b0;
  assign bus.wdog_flag = 1'b0;
`endif

  assign bus.reset   = r_reset;
  assign bus.reset_n = ~r_reset;
  assign bus.busy    = |r_reset;
  assign bus.done    = (r_state == S_RUN);

endmodule

// File: tb/tb_rtc_reset_seq.sv
// Bench for rtc_reset_seq: channel release times predicted from the edge arithmetic
// (hold anchor + HOLD + k*STAGGER), with directed and randomized software re-reset.
`timescale 1ns/1ps
module tb_rtc_reset_seq;
  localparam int SYNC = 2;
  localparam int HOLD = 16;
  localparam int STAG = 8;
  localparam int NCH  = 4;
  localparam int WDOG = 20;

  logic clk_peripheral = 1'b0;
  logic resetn         = 1'b0;
  always #5 clk_peripheral = ~clk_peripheral;

  rtc_reset_seq_if #(.NUM_CH(4)) bus4 ();
  rtc_reset_seq_if #(.NUM_CH(8)) bus8 ();

  rtc_reset_seq #(.NUM_CH(4), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGGER_CYCLES(8),
                  .CNT_W(8), .WDOG_CYCLES(WDOG)) dut (
    .clk_peripheral(clk_peripheral), .resetn(resetn), .bus(bus4));

  rtc_reset_seq #(.NUM_CH(8), .SYNC_STAGES(2), .HOLD_CYCLES(16), .STAGGER_CYCLES(0),
                  .CNT_W(8), .WDOG_CYCLES(200)) dut8 (
    .clk_peripheral(clk_peripheral), .resetn(resetn), .bus(bus8));

  int n;        // rising edges since resetn released
  int anchor;   // edge on which the current hold period started
  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Channel k is still in reset while fewer than HOLD + k*STAG edges have elapsed since the anchor.
  function automatic logic [9:0] exp_vec(input int e, input int a);
    logic [3:0] r;
    for (int k = 0; k < NCH; k++) r[k] = (e - a) < (HOLD + k * STAG);
    return {r, ~r, |r, ~|r};
  endfunction

  function automatic logic [9:0] act_vec();
    return {bus4.reset, bus4.reset_n, bus4.busy, bus4.done};
  endfunction

  task automatic tick(input logic sw, input logic kick);
    bus4.sw_reset_req = sw;
`ifdef RTC_RESET_WDOG_EN
    bus4.wdog_kick = kick;
`else
    if (kick) bus4.sw_reset_req = sw;
`endif
    @(posedge clk_peripheral);
    n++;
    if (sw && n > SYNC) anchor = n;
    #1;
  endtask

  task automatic do_reset(input int cycles);
    resetn = 1'b0;
    repeat (cycles) @(posedge clk_peripheral);
    #1;
    resetn = 1'b1;
    n      = 0;
    anchor = SYNC;
  endtask

  task automatic test_reset();
    bus4.sw_reset_req = 1'b0;
    bus8.sw_reset_req = 1'b0;
`ifdef RTC_RESET_WDOG_EN
    bus4.wdog_kick = 1'b1;
    bus8.wdog_kick = 1'b1;
`endif
    resetn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_peripheral); #1;
      chk_cnt++;
      if (act_vec() !== 10'b1111_0000_1_0)
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, act_vec(), 10'b1111_0000_1_0);
      else pass_cnt++;
    end
    resetn = 1'b1;
    n      = 0;
    anchor = SYNC;
  endtask

  task automatic test_sequence();
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, 1'b1);
      chk_cnt++;
      if (act_vec() !== exp_vec(n, anchor))
        $display("FAIL sequence edge=%0d got=%h want=%h", n, act_vec(), exp_vec(n, anchor));
      else pass_cnt++;
    end
  endtask

  task automatic test_async_mid();
    do_reset(5);
    while (n < 30) tick(1'b0, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk_cnt++;
    if (act_vec() !== 10'b1111_0000_1_0)
      $display("FAIL async_assert got=%h want=%h", act_vec(), 10'b1111_0000_1_0);
    else pass_cnt++;
    repeat (3) @(posedge clk_peripheral);
    #1 resetn = 1'b1;
    n      = 0;
    anchor = SYNC;
    for (int i = 0; i < 45; i++) begin
      tick(1'b0, 1'b1);
      chk_cnt++;
      if (act_vec() !== exp_vec(n, anchor))
        $display("FAIL async_resume edge=%0d got=%h want=%h", n, act_vec(), exp_vec(n, anchor));
      else pass_cnt++;
    end
  endtask

  task automatic test_sw_run();
    int p;
    tick(1'b1, 1'b1);
    p = n;
    chk_cnt++;
    if (bus4.reset !== 4'hF || bus4.done !== 1'b0)
      $display("FAIL sw_run_assert got=%h/%b want=f/0", bus4.reset, bus4.done);
    else pass_cnt++;
    for (int i = 0; i < 42; i++) begin
      tick(1'b0, 1'b1);
      chk_cnt++;
      if (act_vec() !== exp_vec(n, anchor))
        $display("FAIL sw_run edge=%0d got=%h want=%h", n, act_vec(), exp_vec(n, anchor));
      else pass_cnt++;
      if (n - p == 40) begin
        chk_cnt++;
        if (bus4.done !== 1'b1) $display("FAIL sw_run_done40 got=%b want=1", bus4.done);
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_sw_hold();
    int last;
    do_reset(3);
    while (n < 5) tick(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    last = n;
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b1);
      chk_cnt++;
      if (bus4.reset[0] !== ((n - last) < 16))
        $display("FAIL sw_hold_ch0 edge=%0d got=%b want=%b", n, bus4.reset[0], (n - last) < 16);
      else pass_cnt++;
      chk_cnt++;
      if (act_vec() !== exp_vec(n, anchor))
        $display("FAIL sw_hold edge=%0d got=%h want=%h", n, act_vec(), exp_vec(n, anchor));
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    int   burst = 0;
    logic sw;
    do_reset(2);
    for (int i = 0; i < 600; i++) begin
      if (burst > 0) burst--;
      else if ($urandom_range(0, 39) == 0) burst = $urandom_range(1, 5);
      sw = (burst > 0);
      tick(sw, 1'b1);
      chk_cnt++;
      if (act_vec() !== exp_vec(n, anchor))
        $display("FAIL random edge=%0d got=%h want=%h", n, act_vec(), exp_vec(n, anchor));
      else pass_cnt++;
    end
    bus4.sw_reset_req = 1'b0;
  endtask

  task automatic test_stagger0();
    logic [7:0] er;
    do_reset(4);
    for (int i = 0; i < 25; i++) begin
      tick(1'b0, 1'b1);
      er = (n < SYNC + HOLD) ? 8'hFF : 8'h00;
      chk_cnt++;
      if ({bus8.reset, bus8.reset_n, bus8.busy, bus8.done} !== {er, ~er, |er, ~|er})
        $display("FAIL stagger0 edge=%0d got=%h/%b/%b want=%h/%b/%b",
                 n, bus8.reset, bus8.busy, bus8.done, er, |er, ~|er);
      else pass_cnt++;
    end
  endtask

`ifdef RTC_RESET_WDOG_EN
  task automatic test_wdog();
    int t_out;
    do_reset(3);
    tick(1'b1, 1'b0);
    chk_cnt++;
    if (bus4.wdog_flag !== 1'b0) $display("FAIL wdog_clear got=%b want=0", bus4.wdog_flag);
    else pass_cnt++;
    t_out = SYNC + HOLD + (NCH - 1) * STAG + WDOG;
    while (n < 105) begin
      tick(1'b0, 1'b0);
      if (n == t_out) anchor = n;
      chk_cnt++;
      if ({act_vec(), bus4.wdog_flag} !== {exp_vec(n, anchor), n >= t_out})
        $display("FAIL wdog_timeout edge=%0d got=%h/%b want=%h/%b",
                 n, act_vec(), bus4.wdog_flag, exp_vec(n, anchor), n >= t_out);
      else pass_cnt++;
    end
    while (n < 200) begin
      tick(1'b0, (n % 10) == 0);
      chk_cnt++;
      if (act_vec() !== exp_vec(n, anchor))
        $display("FAIL wdog_kicked edge=%0d got=%h want=%h", n, act_vec(), exp_vec(n, anchor));
      else pass_cnt++;
    end
    resetn = 1'b0;
    #1;
    chk_cnt++;
    if (bus4.wdog_flag !== 1'b1) $display("FAIL wdog_sticky got=%b want=1", bus4.wdog_flag);
    else pass_cnt++;
    do_reset(2);
    tick(1'b1, 1'b1);
    chk_cnt++;
    if (bus4.wdog_flag !== 1'b0) $display("FAIL wdog_sync_clear got=%b want=0", bus4.wdog_flag);
    else pass_cnt++;
    bus4.sw_reset_req = 1'b0;
  endtask
`endif

  initial begin
    n      = 0;
    anchor = SYNC;
    test_reset();
    test_sequence();
    test_async_mid();
    test_sw_run();
    test_sw_hold();
    test_random();
    test_stagger0();
`ifdef RTC_RESET_WDOG_EN
    test_wdog();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
